// File: rtl/mem_store_pkg.sv
// ============================================================================
// mem_store_pkg : shared encodings and helpers for the store-side memory unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_store_pkg;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SB  = 2'b01,
    OP_SH  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Reserved opcodes are rejected the same way as a misaligned access.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_SW:   bad = (offset != 2'b00);
      OP_SB:   bad = 1'b0;
      OP_SH:   bad = offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_store_byte_merge.sv
// ============================================================================
// byte_merge : replaces the addressed byte/halfword lane of a word
// Revision   : 1.0
// ============================================================================
`default_nettype none

module byte_merge
  import mem_store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  op_e         op,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  logic [1:0] lane;
  logic       half;

  // Big-endian places offset 0 in the most significant lane.
  always_comb begin
    lane = BIG_ENDIAN ? ~offset    : offset;
    half = BIG_ENDIAN ? ~offset[1] : offset[1];
  end

  always_comb begin
    merged = old_word;
    case (op)
      OP_SW:   merged = new_data;
      OP_SB:   merged[{lane, 3'b000} +: 8] = new_data[7:0];
      OP_SH:   merged[{half, 4'b0000} +: 16] = new_data[15:0];
      default: merged = old_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_store_unit.sv
// ============================================================================
// mem_store_unit : SW/SH/SB store unit with read-modify-write for sub-words
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_store_unit
  import mem_store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state, state_n;
  op_e         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic        accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_misaligned(op_e'(op), addr[1:0])) state_n = ERR;
          else if (op_e'(op) == OP_SW)             state_n = WRITE;
          else                                     state_n = READ;
        end
      end
      READ:    state_n = WRITE;
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_SW;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(op);
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == READ) merge_q <= mem_rd;
    end
  end

  // Only registered values feed the merge, so mem_wd is steady across WRITE.
  byte_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word (merge_q),
    .new_data (wdata_q),
    .op       (op_q),
    .offset   (addr_q[1:0]),
    .merged   (merged)
  );

  assign busy     = (state != IDLE);
  assign done     = (state == DONE) || (state == ERR);
  assign err      = (state == ERR);
  assign mem_we   = (state == WRITE);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wd   = merged;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: a big-endian and a little-endian instance
// run in lockstep, each against its own word memory; writes are scoreboarded.
`default_nettype none

module tb_mem_store_unit;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        busy_be, done_be, err_be, we_be;
  logic [31:0] maddr_be, wd_be, rd_be;
  logic        busy_le, done_le, err_le, we_le;
  logic [31:0] maddr_le, wd_le, rd_le;

  logic [31:0] mem_be [0:255];
  logic [31:0] mem_le [0:255];

  wr_t qb[$];
  wr_t ql[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy_be), .done(done_be), .err(err_be), .mem_addr(maddr_be),
    .mem_we(we_be), .mem_wd(wd_be), .mem_rd(rd_be)
  );

  mem_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy_le), .done(done_le), .err(err_le), .mem_addr(maddr_le),
    .mem_we(we_le), .mem_wd(wd_le), .mem_rd(rd_le)
  );

  assign rd_be = mem_be[maddr_be[9:2]];
  assign rd_le = mem_le[maddr_le[9:2]];

  always @(posedge clk) begin
    if (we_be) mem_be[maddr_be[9:2]] <= wd_be;
    if (we_le) mem_le[maddr_le[9:2]] <= wd_le;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem_be[a[9:2]] = w;
    mem_le[a[9:2]] = w;
  endtask

  // Samples ncyc cycles at the falling edge; pops the scoreboard on every write.
  task automatic watch(input int ncyc, output int n_we, output int done_cyc, output logic err_seen);
    wr_t e;
    n_we = 0;
    done_cyc = 0;
    err_seen = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (we_be) begin
        n_we++;
        if (qb.size() == 0) check("be_unexpected_write", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          check("be_mem_addr", maddr_be, e.a);
          check("be_mem_wd", wd_be, e.d);
        end
      end
      if (we_le) begin
        if (ql.size() == 0) check("le_unexpected_write", 32'd1, 32'd0);
        else begin
          e = ql.pop_front();
          check("le_mem_addr", maddr_le, e.a);
          check("le_mem_wd", wd_le, e.d);
        end
      end
      if (done_be && done_cyc == 0) begin
        done_cyc = c;
        err_seen = err_be;
      end
      if (done_be || done_le) begin
        check("le_done_lockstep", {31'd0, done_le}, {31'd0, done_be});
        check("le_err_lockstep", {31'd0, err_le}, {31'd0, err_be});
      end
    end
  endtask

  // Called at a falling edge; lat is the cycle (after acceptance) carrying done.
  task automatic do_store(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] be_wd,
                          input logic [31:0] le_wd, input int lat, input logic e);
    int   nwe, dc;
    logic es;
    op = o; addr = a; wdata = d; start = 1'b1;
    if (!e) begin
      qb.push_back('{a & ~32'h3, be_wd});
      ql.push_back('{a & ~32'h3, le_wd});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(3, 0)); addr = $urandom; wdata = $urandom;
    check({tag, "_busy"}, {31'd0, busy_be}, 32'd1);
    watch(lat + 2, nwe, dc, es);
    check({tag, "_done_cycle"}, dc, lat);
    check({tag, "_err"}, {31'd0, es}, {31'd0, e});
    check({tag, "_writes"}, nwe, e ? 32'd0 : 32'd1);
    check({tag, "_idle"}, {31'd0, busy_be}, 32'd0);
  endtask

  initial begin
    int   nwe, dc;
    logic es;
    for (int i = 0; i < 256; i++) set_word(32'(i) << 2, 32'h0);

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_be}, 32'd0);
    check("rst_done", {31'd0, done_be}, 32'd0);
    check("rst_err", {31'd0, err_be}, 32'd0);
    check("rst_we", {31'd0, we_be}, 32'd0);
    check("rst_mem_addr", maddr_be, 32'd0);
    check("rst_mem_wd", wd_be, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_store("sw", 2'b00, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0);

    set_word(32'h100, 32'h11223344);
    do_store("sb_off2", 2'b01, 32'h102, 32'h000000AA, 32'h1122AA44, 32'h11AA3344, 3, 1'b0);
    set_word(32'h100, 32'h11223344);
    do_store("sh_off2", 2'b10, 32'h102, 32'h0000BEEF, 32'h1122BEEF, 32'hBEEF3344, 3, 1'b0);
    set_word(32'h100, 32'h11223344);
    do_store("sb_off0", 2'b01, 32'h100, 32'h00000077, 32'h77223344, 32'h11223377, 3, 1'b0);
    set_word(32'h100, 32'h11223344);
    do_store("sb_off1", 2'b01, 32'h101, 32'hFFFFFF5A, 32'h115A3344, 32'h11225A44, 3, 1'b0);
    set_word(32'h100, 32'h11223344);
    do_store("sb_off3", 2'b01, 32'h103, 32'h00000099, 32'h11223399, 32'h99223344, 3, 1'b0);
    set_word(32'h100, 32'h11223344);
    do_store("sh_off0", 2'b10, 32'h100, 32'hFFFFCAFE, 32'hCAFE3344, 32'h1122CAFE, 3, 1'b0);

    do_store("mis_sh", 2'b10, 32'h101, 32'h0000BEEF, 32'h0, 32'h0, 1, 1'b1);
    do_store("mis_sw", 2'b00, 32'h102, 32'h12345678, 32'h0, 32'h0, 1, 1'b1);
    do_store("mis_rsv", 2'b11, 32'h100, 32'h12345678, 32'h0, 32'h0, 1, 1'b1);
    check("mis_mem_untouched", mem_be[8'h40], 32'hCAFE3344);

    // start held high: a fresh SW is accepted every third cycle
    op = 2'b00; addr = 32'h200; wdata = 32'h12345678; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qb.push_back('{32'h200, 32'h12345678});
      ql.push_back('{32'h200, 32'h12345678});
    end
    @(posedge clk);
    watch(12, nwe, dc, es);
    start = 1'b0;
    check("hold_writes", nwe, 32'd4);
    check("hold_done_cycle", dc, 32'd2);
    check("hold_queue_empty", qb.size(), 32'd0);
    @(negedge clk);

    // start kept asserted with different inputs while an SB is in flight
    set_word(32'h104, 32'hCCDDEEFF);
    op = 2'b01; addr = 32'h104; wdata = 32'h00000055; start = 1'b1;
    qb.push_back('{32'h104, 32'h55DDEEFF});
    ql.push_back('{32'h104, 32'hCCDDEE55});
    @(posedge clk);
    #1;
    op = 2'b00; addr = 32'h300; wdata = 32'hFFFFFFFF;
    watch(3, nwe, dc, es);
    start = 1'b0;
    check("busy_start_writes", nwe, 32'd1);
    check("busy_start_done", dc, 32'd3);
    watch(2, nwe, dc, es);
    check("busy_start_not_queued", nwe, 32'd0);
    check("busy_start_mem300", mem_be[8'hC0], 32'h0);

    // reset during the WRITE cycle of an SB aborts the write
    set_word(32'h108, 32'hA1B2C3D4);
    op = 2'b01; addr = 32'h108; wdata = 32'h000000EE; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rst_mid_read_we", {31'd0, we_be}, 32'd0);
    @(negedge clk);
    check("rst_mid_write_we", {31'd0, we_be}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_we_drop", {31'd0, we_be}, 32'd0);
    check("rst_mid_we_drop_le", {31'd0, we_le}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_be}, 32'd0);
    check("rst_mid_done", {31'd0, done_be}, 32'd0);
    @(negedge clk);
    check("rst_mid_done_hold", {31'd0, done_be}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_be", mem_be[8'h42], 32'hA1B2C3D4);
    check("rst_mid_mem_le", mem_le[8'h42], 32'hA1B2C3D4);
    check("rst_mid_no_done", {31'd0, done_be}, 32'd0);

    do_store("sw_after_rst", 2'b00, 32'h10C, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 2, 1'b0);
    check("final_mem_10c", mem_be[8'h43], 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_store_unit.md
# mem_store_unit

Store-side memory access unit for the multicycle MIPS datapath, the write-direction counterpart to the load-byte zero-extension path. It executes SW, SH and SB against a word-wide data memory that has no byte enables. Sub-word stores use a read-modify-write sequence: read the full word, merge the new byte or halfword into the addressed lane, then write the word back. It sits between the multicycle controller and the data-memory port, and reports completion or misalignment through a done/err pulse.

## Interface
- BIG_ENDIAN, default 1: byte lane ordering. When 1, byte offset 0 maps to bits [31:24]. When 0, byte offset 0 maps to bits [7:0].
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request strobe; sampled only when busy=0
- op  in  2  00=SW, 01=SB, 10=SH, 11=reserved (treated as misaligned)
- addr  in  32  byte address of the store
- wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
- busy  out  1  high while a request is in flight
- done  out  1  one-cycle completion pulse
- err  out  1  pulses together with done when the request is rejected
- mem_addr  out  32  word address {addr_q[31:2],2'b00}
- mem_we  out  1  write strobe to data memory
- mem_wd  out  32  write data to data memory
- mem_rd  in  32  combinational read data for mem_addr, valid in the same cycle

## Operation
- States:
  - IDLE: waits for start.
  - READ: word for mem_addr is on mem_rd.
  - WRITE: mem_we=1.
  - DONE: done=1.
  - ERR: done=1, err=1.
- On acceptance (IDLE and start=1), op, addr and wdata are latched. The live inputs are ignored until the unit returns to IDLE.
- Transitions from IDLE:
  - SW with addr[1:0]=00 goes to WRITE.
  - SB goes to READ.
  - SH with addr[0]=0 goes to READ.
  - Anything else (SW with addr[1:0]≠00, SH with addr[0]=1, op=11) goes to ERR.
- READ: mem_rd is captured into merge_q; next state is WRITE.
- WRITE data:
  - SW writes wdata_q.
  - SB/SH write merge_q with only the addressed lane replaced.
  - Next state is DONE.
- DONE and ERR both return to IDLE.
- Lane selection with BIG_ENDIAN=1:
  - SB offset 0/1/2/3 writes bits [31:24]/[23:16]/[15:8]/[7:0].
  - SH offset 0 writes [31:16]; offset 2 writes [15:0].
- With BIG_ENDIAN=0 the lane order is mirrored.
- Unaddressed bytes are written back bit-identical to the value read.
- busy = (state != IDLE).
- mem_we is high only in WRITE. ERR never asserts mem_we.
- start while busy=1 is ignored and not queued.

## Timing
- Reset values: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wd=0; state=IDLE.
- Latency, with start accepted at edge t:
  - SW: WRITE during cycle t+1, done during t+2.
  - SB/SH: READ during t+1, WRITE during t+2, done during t+3.
  - Misaligned: done=err=1 during t+1.
- The earliest next acceptance is the cycle after done, i.e. the edge ending the done cycle plus one. Throughput is one SW per 3 cycles and one SB/SH per 4 cycles.
- mem_addr and mem_wd are registered and stable for the whole READ/WRITE cycle. mem_addr holds its last value in IDLE.
- Reset asserted mid-operation:
  - Everything returns to IDLE immediately and asynchronously.
  - mem_we drops in the same cycle, so a pending write is aborted and nothing is written.
  - No done pulse is produced.

## Structure
- Shared package mem_store_pkg holds:
  - op encodings: OP_SW, OP_SB, OP_SH, OP_RSV
  - state enum: IDLE, READ, WRITE, DONE, ERR
  - a misalignment check function
- One combinational sub-module, byte_merge. Inputs: old word, new data, op, offset[1:0], BIG_ENDIAN parameter. Output: merged word. It is instantiated once in the WRITE data path.
- The remainder is a single FSM plus capture registers (op_q, addr_q, wdata_q, merge_q) in mem_store_unit.

## Test plan
- SW: addr=0x100, wdata=0xDEADBEEF, start. Expected: one mem_we pulse at t+1 with mem_addr=0x100, mem_wd=0xDEADBEEF; done at t+2; err=0.
- SB, BIG_ENDIAN=1: mem word 0x11223344, addr=0x102, wdata=0xAA. Expected: READ at t+1, write of 0x1122AA44 at t+2, done at t+3.
- SH: mem word 0x11223344, addr=0x102, wdata=0xBEEF gives write 0x1122BEEF. With BIG_ENDIAN=0 the same stimulus gives 0xBEEF3344.
- Misaligned: SH at addr=0x101, then SW at addr=0x102, then op=11. Expected: each gives done=err=1 at t+1 and mem_we is never asserted.
- start held high continuously and a start issued while busy. Expected: exactly one store per IDLE acceptance, and the in-flight op's latched addr/wdata are unaffected by changing inputs.
- reset asserted during the WRITE cycle of an SB. Expected: mem_we falls immediately, memory is unchanged, busy=0, no done; a new SW after reset completes normally.
